// File: rtl/mlp_conv_pkg.sv
// ---------------------------------------------------------------------------
// mlp_conv_pkg
// Shared types and constants for the mlp_conv datapath.
//   weight_t    : one weight at the default weight width
//   WORD_BYTES  : weights per packed word at the default widths
//   pk_state_t  : weight_packer FSM state encoding
// ---------------------------------------------------------------------------
package mlp_conv_pkg;

  localparam int DEF_INPUT_WIDTH  = 32;
  localparam int DEF_WEIGHT_WIDTH = 8;
  localparam int WORD_BYTES       = DEF_INPUT_WIDTH / DEF_WEIGHT_WIDTH;

  typedef logic [DEF_WEIGHT_WIDTH-1:0] weight_t;

  typedef enum logic [1:0] {
    PK_IDLE  = 2'd0,
    PK_FILL  = 2'd1,
    PK_DRAIN = 2'd2
  } pk_state_t;

endpackage

// File: rtl/weight_word_accum.sv
// ---------------------------------------------------------------------------
// weight_word_accum
// Builds one packed word from consecutive weights, left-justified from the
// MSB. A word completes after WORD_BYTES weights or early when flush is high
// with the accepted weight (unused low bytes stay zero).
//
// A completing word is offered combinationally on word/complete in the same
// cycle as its last weight so the output register can load with latency 1.
// If take is low at that edge the word is parked here (held=1) until take.
//
// Ports:
//   clk, reset   : clock, synchronous active-high reset
//   clear        : drop any partial or held word
//   load         : accept data this edge
//   flush        : the accepted weight ends the word early
//   take         : whatever word is complete this cycle is consumed
//   data         : incoming weight
//   word         : held word if any, else the word completing now
//   complete     : a word is available (held or completing now)
//   held         : a completed word is parked in the accumulator
// ---------------------------------------------------------------------------
module weight_word_accum #(
  parameter int INPUT_WIDTH  = 32,
  parameter int WEIGHT_WIDTH = 8
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    clear,
  input  logic                    load,
  input  logic                    flush,
  input  logic                    take,
  input  logic [WEIGHT_WIDTH-1:0] data,
  output logic [INPUT_WIDTH-1:0]  word,
  output logic                    complete,
  output logic                    held
);

  localparam int WB = INPUT_WIDTH / WEIGHT_WIDTH;
  localparam int CW = (WB > 1) ? $clog2(WB) : 1;

  logic [INPUT_WIDTH-1:0] acc_q;
  logic [CW-1:0]          cnt_q;
  logic                   held_q;

  logic [INPUT_WIDTH-1:0] placed;
  logic [INPUT_WIDTH-1:0] cand;
  logic                   ends;

  always_comb begin
    placed   = {data, {(INPUT_WIDTH-WEIGHT_WIDTH){1'b0}}} >> (WEIGHT_WIDTH * int'(cnt_q));
    // A held word is never a base for new weights: new weights only arrive
    // while it is being taken, so they start a fresh word.
    cand     = (held_q ? '0 : acc_q) | placed;
    ends     = load & (flush | (cnt_q == CW'(WB-1)));
    word     = held_q ? acc_q : cand;
    complete = held_q | ends;
    held     = held_q;
  end

  always_ff @(posedge clk) begin
    if (reset || clear) begin
      acc_q  <= '0;
      cnt_q  <= '0;
      held_q <= 1'b0;
    end else begin
      if (held_q && take) begin
        held_q <= 1'b0;
        acc_q  <= '0;
      end
      if (load) begin
        if (ends) begin
          cnt_q <= '0;
          // Park the new word unless it goes straight to the output register
          // (only possible when nothing was already parked).
          if (held_q || !take) begin
            acc_q  <= cand;
            held_q <= 1'b1;
          end else begin
            acc_q <= '0;
          end
        end else begin
          acc_q <= cand;
          cnt_q <= cnt_q + CW'(1);
        end
      end
    end
  end

endmodule

// File: rtl/weight_packer.sv
// ---------------------------------------------------------------------------
// weight_packer
// Packs an R x S filter of weights (row-major, MSB weight first) into
// INPUT_WIDTH-bit words in the layout weight_buffer unpacks.
//   Row mode   (S*WEIGHT_WIDTH <= INPUT_WIDTH): one left-justified word per row.
//   Dense mode (otherwise): one MSB-first bitstream cut into words, last word
//              zero-padded.
//
// Handshakes (valid/ready): a weight transfers on an edge with
// IN_VALID & IN_READY; a word transfers on an edge with WR_VALID & WR_EN,
// where WR_EN = WR_VALID & ~FULL. WR_DATA is stable while WR_VALID is high
// and the word has not transferred. Neither side may retract valid.
//
// Optional feature: define WEIGHT_PACKER_STALL_CNT_EN to add STALL_CNT, a
// saturating count of cycles with WR_VALID & FULL.
//
// Ports:
//   CLK, RESET        : clock, synchronous active-high reset
//   START             : begin a filter (IDLE only), latches PARAM_R/PARAM_S
//   PARAM_R, PARAM_S  : filter height / width, legal 1..MAX_R / 1..MAX_S
//   IN_VALID/IN_READY/IN_DATA : weight stream
//   FULL              : backpressure from weight_buffer
//   WR_EN/WR_VALID/WR_DATA    : packed word output
//   BUSY              : not IDLE
//   DONE              : one-cycle pulse after the final word transfers
//   ERR               : sticky, set by an illegal START
//   STALL_CNT         : optional stall counter
//   STATE_DBG         : current FSM state (pk_state_t encoding)
// ---------------------------------------------------------------------------
module weight_packer
  import mlp_conv_pkg::*;
#(
  parameter int INPUT_WIDTH  = DEF_INPUT_WIDTH,
  parameter int WEIGHT_WIDTH = DEF_WEIGHT_WIDTH,
  parameter int MAX_R        = 5,
  parameter int MAX_S        = 5
) (
  input  logic                    CLK,
  input  logic                    RESET,
  input  logic                    START,
  input  logic [3:0]              PARAM_R,
  input  logic [3:0]              PARAM_S,
  input  logic                    IN_VALID,
  output logic                    IN_READY,
  input  logic [WEIGHT_WIDTH-1:0] IN_DATA,
  input  logic                    FULL,
  output logic                    WR_EN,
  output logic                    WR_VALID,
  output logic [INPUT_WIDTH-1:0]  WR_DATA,
  output logic                    BUSY,
  output logic                    DONE,
  output logic                    ERR,
`ifdef WEIGHT_PACKER_STALL_CNT_EN
  output logic [15:0]             STALL_CNT,
`endif
  output logic [1:0]              STATE_DBG
);

  localparam logic [3:0] MAX_R4 = 4'(MAX_R);
  localparam logic [3:0] MAX_S4 = 4'(MAX_S);

  pk_state_t              state_q;
  logic [3:0]             r_q, s_q, col_q, row_q;
  logic                   wr_valid_q;
  logic [INPUT_WIDTH-1:0] wr_data_q;
  logic                   done_q, err_q;

  logic                   start_legal, start_go;
  logic                   out_avail, wr_xfer, accept;
  logic                   row_mode, last_in_row, last_weight, flush;
  logic [31:0]            s_bits;
  logic [INPUT_WIDTH-1:0] acc_word;
  logic                   acc_complete, acc_held;

  always_comb begin
    start_legal = (PARAM_R != 4'd0) && (PARAM_R <= MAX_R4) &&
                  (PARAM_S != 4'd0) && (PARAM_S <= MAX_S4);
    start_go    = START && (state_q == PK_IDLE) && start_legal;
    // The output register can take a word if empty or emptying this edge.
    out_avail   = !wr_valid_q || !FULL;
    wr_xfer     = wr_valid_q && !FULL;
    IN_READY    = (state_q == PK_FILL) && (!acc_held || out_avail);
    accept      = IN_VALID && IN_READY;
    s_bits      = 32'(s_q) * 32'(WEIGHT_WIDTH);
    row_mode    = s_bits <= 32'(INPUT_WIDTH);
    last_in_row = (col_q == s_q - 4'd1);
    last_weight = last_in_row && (row_q == r_q - 4'd1);
    flush       = last_weight || (row_mode && last_in_row);
  end

  weight_word_accum #(
    .INPUT_WIDTH (INPUT_WIDTH),
    .WEIGHT_WIDTH(WEIGHT_WIDTH)
  ) u_accum (
    .clk     (CLK),
    .reset   (RESET),
    .clear   (start_go),
    .load    (accept),
    .flush   (flush),
    .take    (out_avail),
    .data    (IN_DATA),
    .word    (acc_word),
    .complete(acc_complete),
    .held    (acc_held)
  );

  always_ff @(posedge CLK) begin
    if (RESET) begin
      state_q    <= PK_IDLE;
      r_q        <= 4'd0;
      s_q        <= 4'd0;
      col_q      <= 4'd0;
      row_q      <= 4'd0;
      wr_valid_q <= 1'b0;
      wr_data_q  <= '0;
      done_q     <= 1'b0;
      err_q      <= 1'b0;
    end else begin
      done_q <= 1'b0;

      if (out_avail && acc_complete) begin
        wr_valid_q <= 1'b1;
        wr_data_q  <= acc_word;
      end else if (wr_xfer) begin
        wr_valid_q <= 1'b0;
      end

      case (state_q)
        PK_IDLE: begin
          if (START) begin
            if (start_legal) begin
              r_q     <= PARAM_R;
              s_q     <= PARAM_S;
              col_q   <= 4'd0;
              row_q   <= 4'd0;
              err_q   <= 1'b0;
              state_q <= PK_FILL;
            end else begin
              err_q <= 1'b1;
            end
          end
        end
        PK_FILL: begin
          if (accept) begin
            if (last_in_row) begin
              col_q <= 4'd0;
              if (last_weight) begin
                row_q   <= 4'd0;
                state_q <= PK_DRAIN;
              end else begin
                row_q <= row_q + 4'd1;
              end
            end else begin
              col_q <= col_q + 4'd1;
            end
          end
        end
        PK_DRAIN: begin
          // Final transfer: output register empties with nothing parked.
          if (wr_xfer && !acc_held) begin
            state_q <= PK_IDLE;
            done_q  <= 1'b1;
          end
        end
        default: state_q <= PK_IDLE;
      endcase
    end
  end

`ifdef WEIGHT_PACKER_STALL_CNT_EN
  logic [15:0] stall_q;
  always_ff @(posedge CLK) begin
    if (RESET || start_go) begin
      stall_q <= 16'd0;
    end else if (wr_valid_q && FULL && (stall_q != 16'hFFFF)) begin
      stall_q <= stall_q + 16'd1;
    end
  end
  assign STALL_CNT = stall_q;
`endif

  assign WR_EN     = wr_valid_q && !FULL;
  assign WR_VALID  = wr_valid_q;
  assign WR_DATA   = wr_data_q;
  assign BUSY      = (state_q != PK_IDLE);
  assign DONE      = done_q;
  assign ERR       = err_q;
  assign STATE_DBG = state_q;

endmodule

// File: tb/tb_weight_packer.sv
// ---------------------------------------------------------------------------
// tb_weight_packer
// Directed and randomized filters driven into weight_packer. Expected words
// come from a bit-packing model of the filter; a negedge monitor pops them on
// each transfer and checks hold stability under FULL.
// ---------------------------------------------------------------------------
module tb_weight_packer;
  import mlp_conv_pkg::*;

  logic        CLK = 1'b0;
  logic        RESET, START, IN_VALID, FULL;
  logic [3:0]  PARAM_R, PARAM_S;
  logic [7:0]  IN_DATA;
  logic        IN_READY, WR_EN, WR_VALID, BUSY, DONE, ERR;
  logic [31:0] WR_DATA;
  logic [1:0]  STATE_DBG;
`ifdef WEIGHT_PACKER_STALL_CNT_EN
  logic [15:0] STALL_CNT;
`endif

  weight_packer dut (
    .CLK(CLK), .RESET(RESET), .START(START), .PARAM_R(PARAM_R), .PARAM_S(PARAM_S),
    .IN_VALID(IN_VALID), .IN_READY(IN_READY), .IN_DATA(IN_DATA), .FULL(FULL),
    .WR_EN(WR_EN), .WR_VALID(WR_VALID), .WR_DATA(WR_DATA), .BUSY(BUSY),
    .DONE(DONE), .ERR(ERR),
`ifdef WEIGHT_PACKER_STALL_CNT_EN
    .STALL_CNT(STALL_CNT),
`endif
    .STATE_DBG(STATE_DBG)
  );

  // clock / reset
  always #5 CLK = ~CLK;

  int cyc = 0;
  always @(posedge CLK) cyc++;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish, observed cycle %0d required < 200000", cyc);
    $fatal(1, "watchdog");
  end

  // scoreboard state
  logic [31:0] exp_q[$];
  logic [7:0]  wts[$];
  bit          word_end[$];
  int          checks = 0;
  int          fails  = 0;
  int          xfer_cnt = 0;
  int          last_xfer_cyc = -10;
  int          stall_seen = 0;
  bit          hold_pend = 1'b0;
  logic [31:0] hold_data;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Output monitor: sampled at negedge, transfer happens at the next posedge.
  always @(negedge CLK) begin
    if (hold_pend) begin
      chk("wr_hold_valid", WR_VALID, 1);
      chk("wr_hold_data", WR_DATA, hold_data);
    end
    hold_pend = WR_VALID && FULL && !RESET;
    hold_data = WR_DATA;
    if (WR_VALID && FULL && !RESET) stall_seen++;
    if (FULL) chk("wr_en_under_full", WR_EN, 0);
    if (WR_EN) begin
      chk("wr_expected", 32'(exp_q.size() != 0), 1);
      if (exp_q.size() != 0) chk("wr_data", WR_DATA, exp_q.pop_front());
      xfer_cnt++;
      last_xfer_cyc = cyc;
    end
  end

  // reference model: weights placed MSB-first by position within the word
  task automatic build_model(input int r, input int s);
    int n, col, pos;
    bit ends, rowm;
    logic [31:0] word;
    n = r * s;
    rowm = (s * 8 <= 32);
    word = 32'd0;
    word_end.delete();
    for (int i = 0; i < n; i++) begin
      col  = i % s;
      pos  = rowm ? (col % 4) : (i % 4);
      word = word | (32'(wts[i]) << (24 - 8 * pos));
      ends = (pos == 3) || (i == n - 1) || (rowm && (col == s - 1));
      word_end.push_back(ends);
      if (ends) begin
        exp_q.push_back(word);
        word = 32'd0;
      end
    end
  endtask

  task automatic fill_seq(input int n);
    wts.delete();
    for (int i = 0; i < n; i++) wts.push_back(8'(i + 1));
  endtask

  task automatic fill_rand(input int n);
    wts.delete();
    for (int i = 0; i < n; i++) wts.push_back(8'($urandom_range(0, 255)));
  endtask

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic do_start(input int r, input int s);
    START = 1'b1;
    PARAM_R = 4'(r);
    PARAM_S = 4'(s);
    tick();
    START = 1'b0;
  endtask

  task automatic check_reset_vals(input string tag);
    chk({tag, "_in_ready"}, IN_READY, 0);
    chk({tag, "_wr_en"}, WR_EN, 0);
    chk({tag, "_wr_valid"}, WR_VALID, 0);
    chk({tag, "_wr_data"}, WR_DATA, 0);
    chk({tag, "_busy"}, BUSY, 0);
    chk({tag, "_done"}, DONE, 0);
    chk({tag, "_err"}, ERR, 0);
    chk({tag, "_state"}, 32'(STATE_DBG), 32'(PK_IDLE));
`ifdef WEIGHT_PACKER_STALL_CNT_EN
    chk({tag, "_stall_cnt"}, 32'(STALL_CNT), 0);
`endif
  endtask

  // driver: mode 0 clean, 1 random FULL/gaps/ignored START, 2 directed stalls
  task automatic run_filter(input int r, input int s, input int mode, input int abort_at);
    int n, acc_cnt, budget, full_left, done_words, pending;
    bit s1, s2, got_done;
    n = r * s;
    acc_cnt = 0; budget = 0; full_left = 0; done_words = 0;
    s1 = 0; s2 = 0; got_done = 0;
    build_model(r, s);
    do_start(r, s);
    stall_seen = 0;
    chk("err_after_start", ERR, 0);
    chk("busy_after_start", BUSY, 1);
    xfer_cnt = 0;
    while (acc_cnt < n && budget < 2000) begin
      if (abort_at > 0 && acc_cnt == abort_at) break;
      if (mode == 2) begin
        if (acc_cnt == 8 && !s1) begin full_left = 3; s1 = 1; end
        if (acc_cnt == 16 && !s2) begin full_left = 6; s2 = 1; end
        FULL = (full_left > 0);
        if (full_left > 0) full_left--;
      end else if (mode == 1) begin
        FULL = ($urandom_range(0, 3) == 0);
      end else begin
        FULL = 1'b0;
      end
      IN_VALID = (mode == 1) ? ($urandom_range(0, 4) != 0) : 1'b1;
      IN_DATA  = wts[acc_cnt];
      START    = (mode == 1) && (acc_cnt == 5);
      if (START) begin PARAM_R = 4'd1; PARAM_S = 4'd1; end
      @(negedge CLK);
      #1;
      pending = done_words - xfer_cnt;
      chk("in_ready", IN_READY, !(pending >= 2 && FULL));
      if (mode == 2 && FULL && s1 && !s2) begin
        chk("stall_data", WR_DATA, 32'h05060708);
        chk("stall_wr_en", WR_EN, 0);
      end
      if (IN_VALID && IN_READY) begin
        if (word_end[acc_cnt]) done_words++;
        acc_cnt++;
      end
      tick();
      budget++;
    end
    IN_VALID = 1'b0;
    START = 1'b0;
    if (abort_at > 0) begin
      RESET = 1'b1;
      FULL  = 1'b1;
      @(posedge CLK);
      @(negedge CLK);
      check_reset_vals("mid_reset");
      exp_q.delete();
      RESET = 1'b0;
      FULL  = 1'b0;
      tick();
      return;
    end
    chk("fill_complete", 32'(acc_cnt), 32'(n));
    for (int i = 0; i < 300 && !got_done; i++) begin
      FULL = (mode == 1 && i < 10) ? ($urandom_range(0, 2) == 0) : 1'b0;
      @(negedge CLK);
      #1;
      if (DONE) begin
        got_done = 1;
        chk("done_timing", 32'(cyc), 32'(last_xfer_cyc + 1));
        chk("done_busy", BUSY, 0);
        chk("done_words_left", 32'(exp_q.size()), 0);
`ifdef WEIGHT_PACKER_STALL_CNT_EN
        chk("stall_cnt", 32'(STALL_CNT), 32'(stall_seen));
`endif
      end
      tick();
    end
    chk("done_seen", 32'(got_done), 1);
    @(negedge CLK);
    #1;
    chk("done_pulse", DONE, 0);
    exp_q.delete();
    tick();
  endtask

  int rr, ss;

  initial begin
    RESET = 1'b1; START = 1'b0; IN_VALID = 1'b0; FULL = 1'b0;
    PARAM_R = 4'd0; PARAM_S = 4'd0; IN_DATA = 8'd0;
    @(posedge CLK);
    @(posedge CLK);
    #1;
    check_reset_vals("reset");
    RESET = 1'b0;
    tick();

    fill_seq(25); run_filter(5, 5, 0, 0);
    fill_seq(16); run_filter(4, 4, 0, 0);
    fill_seq(9);  run_filter(3, 3, 0, 0);
    fill_seq(25); run_filter(5, 5, 2, 0);

    do_start(0, 3);
    chk("err_r0", ERR, 1);
    chk("busy_r0", BUSY, 0);
    repeat (3) tick();
    chk("err_sticky", ERR, 1);
    chk("err_no_write", WR_VALID, 0);
    do_start(3, 6);
    chk("err_s6", ERR, 1);
    chk("busy_s6", BUSY, 0);
    fill_rand(9); run_filter(3, 3, 0, 0);

    fill_rand(25); run_filter(5, 5, 0, 12);
    fill_seq(9);   run_filter(3, 3, 0, 0);

    fill_rand(1);  run_filter(1, 1, 1, 0);
    fill_rand(5);  run_filter(5, 1, 1, 0);
    fill_rand(5);  run_filter(1, 5, 1, 0);
    fill_rand(8);  run_filter(2, 4, 1, 0);
    fill_rand(20); run_filter(4, 5, 1, 0);
    for (int k = 0; k < 6; k++) begin
      rr = $urandom_range(1, 5);
      ss = $urandom_range(1, 5);
      fill_rand(rr * ss);
      run_filter(rr, ss, 1, 0);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule

// File: doc/weight_packer.md
# weight_packer

Transmit-side companion to `weight_buffer`. Accepts an R×S filter as a stream of 8-bit weights, row-major and MSB-weight first. Packs the weights into 32-bit `WR_DATA` words in exactly the bit layout `weight_buffer` unpacks into its 40-bit rows. Sits between the weight DMA/stream source and `weight_buffer` inside the `mlp_conv` datapath.

## Interface
Parameters:
- `INPUT_WIDTH`, 32: output word width; must equal `weight_buffer.INPUT_WIDTH`.
- `WEIGHT_WIDTH`, 8: width of one weight.
- `MAX_R`, 5: largest supported filter height.
- `MAX_S`, 5: largest supported filter width.

Ports:
- `CLK` in 1: the single clock; all state updates on its rising edge.
- `RESET` in 1: synchronous, active-high reset.
- `START` in 1: one-cycle pulse; latches `PARAM_R`/`PARAM_S` and begins a filter. Accepted only in IDLE.
- `PARAM_R` in 4: filter height, legal range 1..`MAX_R`.
- `PARAM_S` in 4: filter width, legal range 1..`MAX_S`.
- `IN_VALID` in 1: `IN_DATA` carries a weight.
- `IN_READY` out 1: packer accepts the weight this cycle.
- `IN_DATA` in `WEIGHT_WIDTH`: the weight.
- `FULL` in 1: backpressure from `weight_buffer`.
- `WR_EN` out 1: write enable to `weight_buffer`.
- `WR_VALID` out 1: `WR_DATA` holds a pending word.
- `WR_DATA` out `INPUT_WIDTH`: the packed word.
- `BUSY` out 1: high in any state other than IDLE.
- `DONE` out 1: one-cycle pulse after the last word transfers.
- `ERR` out 1: sticky flag for illegal parameters; cleared by `RESET` or by a legal `START`.

## Operation
- States and transitions:
  - IDLE: a legal `START` → FILL. An illegal `START` (R or S equal to 0 or above max) sets `ERR` and stays in IDLE.
  - FILL: accumulates weights → DRAIN once the last weight is accepted.
  - DRAIN: waits until the final word transfers → IDLE and pulses `DONE`.
- Input handshake: a weight is accepted on an edge where `IN_VALID & IN_READY`.
  - `IN_READY` = state is FILL AND (accumulator not complete OR output register free or freeing this cycle).
- Packing mode is chosen by `S*WEIGHT_WIDTH`:
  - Row mode, `S*WEIGHT_WIDTH <= INPUT_WIDTH`: one word per row. Weights are left-justified from bit 31 downward and unused low bytes are zero. Words per filter = R.
  - Dense mode, otherwise: all R*S weights form one contiguous MSB-first bitstream cut into 32-bit words. Rows cross word boundaries. The final word is zero-padded in the LSBs. Words per filter = ceil(R*S*8/32); a 5×5 filter gives 7 words.
- A word becomes complete on any of:
  - 4 weights accumulated;
  - end of row, in row mode;
  - the last weight of the filter.
- A complete word moves into the output register, which sets `WR_VALID`.
- Output handshake:
  - `WR_EN` = `WR_VALID & ~FULL`.
  - A word transfers on an edge where `WR_EN & WR_VALID`.
  - `WR_DATA` must be stable while `WR_VALID` is high and not yet transferred.
- Counters:
  - weight-in-row counter, 0..S-1;
  - row counter, 0..R-1;
  - byte-in-word counter, 0..3.
- Simultaneous events: when the output register transfers on the same edge that the accumulator completes, the new word loads with no bubble.
- `START` while `BUSY` is ignored.

## Timing
- Reset values: `IN_READY`=0, `WR_EN`=0, `WR_VALID`=0, `WR_DATA`=0, `BUSY`=0, `DONE`=0, `ERR`=0; state IDLE; all counters 0.
- `START` at edge N → `IN_READY` may be high from cycle N+1.
- Last weight of a word accepted at edge N → `WR_VALID`=1 in cycle N+1 (latency 1).
- Throughput is 1 weight/cycle with `FULL`=0.
- With `FULL` held high, the packer absorbs at most one further word in the accumulator, then drops `IN_READY`.
- `DONE` is high in the cycle after the final transfer. `BUSY` falls in that same cycle.
- `RESET` mid-filter returns to the reset values on the next edge and drops partial data. No word is emitted.

## Configuration
- `WEIGHT_PACKER_STALL_CNT_EN`, when defined, adds:
  - output `STALL_CNT[15:0]`, which counts cycles with `WR_VALID & FULL`;
  - saturation at 0xFFFF;
  - clearing by `RESET` or by a legal `START`.
- When not defined, the port and the counter are absent.

## Structure
- Shared package `mlp_conv_pkg` holds:
  - the `weight_t` typedef;
  - the `WORD_BYTES` = `INPUT_WIDTH`/`WEIGHT_WIDTH` constant;
  - the packer state enum.
- One sub-module, `weight_word_accum`: the byte accumulator with its byte counter, a left-justify/flush input, and a complete flag. The FSM and output register stay in the top level.

## Test plan
- 5×5, weights 0x01..0x19, `FULL`=0 → 7 words: 01020304, 05060708, 090A0B0C, 0D0E0F10, 11121314, 15161718, 19000000; `DONE` one cycle after the 7th word.
- 4×4, weights 0x01..0x10 → 4 words: 01020304, 05060708, 090A0B0C, 0D0E0F10.
- 3×3, weights 0x01..0x09 → 3 words: 01020300, 04050600, 07080900.
- 5×5 with `FULL` high for 3 cycles while word 2 is pending → `WR_DATA` = 05060708 held stable, `WR_EN`=0 during the stall, `IN_READY` drops once the next word completes, and the word sequence is unchanged.
- `START` with R=0 or S=6 → `ERR`=1, `BUSY`=0, no writes. A following legal `START` clears `ERR`.
- `RESET` after 12 weights of a 5×5 filter → all outputs reach their reset values next cycle. A fresh 3×3 filter afterwards produces the correct words.
